// File: rtl/display_update_scheduler_if.sv
// rtl/display_update_scheduler_if.sv - request-side link between the update scheduler and output_wrapper
interface display_update_scheduler_if;
  logic       stb;
  logic       write_config;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [5:0] dp;
  logic       busy;
  logic       ack;

  modport master (
    output stb, write_config, hours, minutes, seconds, dp,
    input  busy, ack
  );

  modport slave (
    input  stb, write_config, hours, minutes, seconds, dp,
    output busy, ack
  );
endinterface

// File: rtl/display_update_scheduler.sv
// rtl/display_update_scheduler.sv - arbitrates config/time/refresh display updates; DISPLAY_SCHED_TIMEOUT_EN adds a WAIT timeout
module display_update_scheduler #(
  parameter int unsigned REFRESH_CYCLES     = 50_000_000,
  parameter int unsigned CONFIG_REFRESH_DIV = 16,
  parameter int unsigned TIMEOUT_CYCLES     = 4096
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic                              i_time_stb,
  input  logic                              i_config_stb,
  input  logic [4:0]                        i_hours,
  input  logic [5:0]                        i_minutes,
  input  logic [5:0]                        i_seconds,
  input  logic [5:0]                        i_dp,
  display_update_scheduler_if.master        disp,
  output logic                              o_busy,
  output logic                              o_timeout
);

  localparam int unsigned REF_W = $clog2(REFRESH_CYCLES);
  localparam int unsigned DIV_W = $clog2(CONFIG_REFRESH_DIV + 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CONFIG_REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             issue;
  logic             timeout_hit;
  logic             pend_cfg;
  logic             pend_time;
  logic             pend_ref;
  logic [REF_W-1:0] ref_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             ref_wrap;
  logic             refresh_cfg;
  logic             refresh_dig;
  logic             issue_dig;

  assign ref_wrap    = (ref_cnt == REF_LAST);
  assign refresh_cfg = ref_wrap && (div_cnt == DIV_LAST);
  assign refresh_dig = ref_wrap && (div_cnt != DIV_LAST);
  assign issue_dig   = issue && !pend_cfg;

  assign o_busy   = (state_q != S_IDLE);
  assign disp.stb = (state_q == S_ISSUE);

  // Free-running refresh timer; every Nth wrap asks for a config rewrite instead of digits
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ref_cnt <= '0;
      div_cnt <= '0;
    end else if (ref_wrap) begin
      ref_cnt <= '0;
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Pending request flags: cleared on issue, a new request in the same cycle re-sets them
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pend_cfg  <= 1'b1;
      pend_time <= 1'b0;
      pend_ref  <= 1'b0;
    end else begin
      pend_cfg  <= (pend_cfg && !issue) || i_config_stb || refresh_cfg || timeout_hit;
      pend_time <= (pend_time && !issue_dig) || i_time_stb;
      pend_ref  <= (pend_ref && !issue_dig) || refresh_dig;
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic and issue decision
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((pend_cfg || pend_time || pend_ref) && !disp.busy) begin
          state_d = S_ISSUE;
          issue   = 1'b1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (disp.ack || timeout_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latch request type and, for digit writes, a coherent snapshot of the time
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      disp.write_config <= 1'b0;
      disp.hours        <= '0;
      disp.minutes      <= '0;
      disp.seconds      <= '0;
      disp.dp           <= '0;
    end else if (issue) begin
      disp.write_config <= pend_cfg;
      if (!pend_cfg) begin
        disp.hours   <= i_hours;
        disp.minutes <= i_minutes;
        disp.seconds <= i_seconds;
        disp.dp      <= i_dp;
      end
    end
  end

`ifdef DISPLAY_SCHED_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] wait_cnt;

  assign timeout_hit = (state_q == S_WAIT) && !disp.ack && (wait_cnt == TO_LAST);

  // Cycles spent waiting for ack; restarts each time a strobe goes out
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)               wait_cnt <= '0;
    else if (state_q == S_ISSUE)  wait_cnt <= '0;
    else if (state_q == S_WAIT)   wait_cnt <= wait_cnt + 1'b1;
  end

  // One-cycle abort indication
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) o_timeout <= 1'b0;
    else            o_timeout <= timeout_hit;
  end
`else
  assign timeout_hit = 1'b0;
  // The timeout length has no meaning in this build; the output is constant low
  assign o_timeout   = (TIMEOUT_CYCLES == 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: tb/tb_display_update_scheduler.sv
// tb/tb_display_update_scheduler.sv - self-checking bench for display_update_scheduler
module tb_display_update_scheduler;

  localparam int REFRESH = 20;
  localparam int DIV     = 3;
  localparam int TIMEOUT = 8;
`ifdef DISPLAY_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       time_stb = 1'b0;
  logic       config_stb = 1'b0;
  logic [4:0] hours_i = '0;
  logic [5:0] minutes_i = '0;
  logic [5:0] seconds_i = '0;
  logic [5:0] dp_i = '0;
  logic       busy_r = 1'b0;
  logic       ack_r = 1'b0;
  logic       o_busy;
  logic       o_timeout;

  int checks = 0;
  int errors = 0;

  display_update_scheduler_if dif ();
  assign dif.busy = busy_r;
  assign dif.ack  = ack_r;

  display_update_scheduler #(
    .REFRESH_CYCLES(REFRESH),
    .CONFIG_REFRESH_DIV(DIV),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_reset_n(reset_n),
    .i_time_stb(time_stb),
    .i_config_stb(config_stb),
    .i_hours(hours_i),
    .i_minutes(minutes_i),
    .i_seconds(seconds_i),
    .i_dp(dp_i),
    .disp(dif.master),
    .o_busy(o_busy),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // output_wrapper stand-in: ack five cycles after each strobe
  bit resp_en = 1'b1;
  int ack_cnt = 0;
  always @(negedge clk) begin
    ack_r = 1'b0;
    if (ack_cnt != 0) begin
      ack_cnt--;
      if (ack_cnt == 0) ack_r = 1'b1;
    end
    if (resp_en && dif.stb === 1'b1) ack_cnt = 5;
  end

  // Reference model: pending requests as two sets (config / digits), one transaction outstanding at a time
  int         m_k = 0;
  int         m_issue = 0;
  bit         m_cfg, m_dig, m_out, m_free, m_started = 1'b0;
  logic       e_stb, e_wc, e_to;
  logic [4:0] e_h;
  logic [5:0] e_m, e_s, e_dp;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_k = 0; m_cfg = 1; m_dig = 0; m_out = 0; m_issue = 0;
      e_stb = 0; e_wc = 0; e_to = 0; e_h = 0; e_m = 0; e_s = 0; e_dp = 0;
      m_started = 1;
    end else begin
      m_k++;
      e_stb = 0;
      e_to  = 0;
      m_free = !m_out;
      if (m_out && m_k >= m_issue + 2) begin
        if (ack_r) m_out = 0;
        else if (TO_EN && m_k == m_issue + 1 + TIMEOUT) begin
          m_out = 0;
          e_to  = 1;
        end
      end
      if (m_free && (m_cfg || m_dig) && !busy_r) begin
        e_stb = 1; m_out = 1; m_issue = m_k; e_wc = m_cfg;
        if (m_cfg) m_cfg = 0;
        else begin
          m_dig = 0;
          e_h = hours_i; e_m = minutes_i; e_s = seconds_i; e_dp = dp_i;
        end
      end
      if (time_stb) m_dig = 1;
      if (config_stb || e_to) m_cfg = 1;
      if (m_k % REFRESH == 0) begin
        if ((m_k / REFRESH) % DIV == 0) m_cfg = 1;
        else                            m_dig = 1;
      end
    end
  end

  typedef struct {
    int         k;
    logic       wc;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } txn_t;
  txn_t log_q[$];
  int   to_count = 0;

  // Per-cycle comparison of every output against the model, plus transaction log
  always @(negedge clk) begin
    if (m_started) begin
      chk("stb", dif.stb, e_stb);
      chk("write_config", dif.write_config, e_wc);
      chk("busy", o_busy, m_out);
      chk("timeout", o_timeout, e_to);
      chk("hours", dif.hours, e_h);
      chk("minutes", dif.minutes, e_m);
      chk("seconds", dif.seconds, e_s);
      chk("dp", dif.dp, e_dp);
      if (dif.stb === 1'b1) log_q.push_back('{m_k, dif.write_config, dif.hours, dif.minutes, dif.seconds});
      if (o_timeout === 1'b1) to_count++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int i = 0; i < budget && log_q.size() < n; i++) step();
    chk("wait_txn_count", log_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && o_busy !== 1'b0; i++) step();
    chk("wait_idle", o_busy, 1'b0);
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 2 * REFRESH && (m_k % REFRESH) != ph; i++) step();
    chk("wait_phase", m_k % REFRESH, ph);
  endtask

  int n;
  int t0;

  initial begin
    repeat (3) step();
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_stb", dif.stb, 1'b0);
    chk("reset_wc", dif.write_config, 1'b0);
    chk("reset_timeout", o_timeout, 1'b0);
    reset_n = 1'b1;

    // first transaction: config, strobe sampled by wrapper at edge 2
    wait_log(1, 10);
    chk("first_edge", log_q[0].k, 1);
    chk("first_is_config", log_q[0].wc, 1'b1);
    wait_idle(12);

    // snapshot must hold while inputs change during WAIT
    wait_phase(1);
    n = log_q.size();
    hours_i = 5'd12; minutes_i = 6'd34; seconds_i = 6'd56; dp_i = 6'h15;
    time_stb = 1'b1; step(); time_stb = 1'b0;
    wait_log(n + 1, 10);
    chk("snap_is_digit", log_q[n].wc, 1'b0);
    chk("snap_hours_issue", log_q[n].h, 5'd12);
    step();
    hours_i = 5'd13; minutes_i = 6'd0; seconds_i = 6'd0;
    step(); step();
    chk("snap_hours_hold", dif.hours, 5'd12);
    chk("snap_minutes_hold", dif.minutes, 6'd34);
    chk("snap_seconds_hold", dif.seconds, 6'd56);
    wait_idle(12);

    // config and time in the same cycle: config first, digit right after ack
    wait_phase(1);
    n = log_q.size();
    time_stb = 1'b1; config_stb = 1'b1; step();
    time_stb = 1'b0; config_stb = 1'b0;
    wait_log(n + 2, 25);
    chk("both_first_config", log_q[n].wc, 1'b1);
    chk("both_second_digit", log_q[n+1].wc, 1'b0);
    chk("both_spacing", log_q[n+1].k - log_q[n].k, 7);
    wait_idle(12);

    // three time pulses during one WAIT coalesce into one more transaction
    wait_phase(1);
    n = log_q.size();
    time_stb = 1'b1; step(); time_stb = 1'b0;
    wait_log(n + 1, 10);
    step();
    time_stb = 1'b1; step(); step(); step(); time_stb = 1'b0;
    t0 = m_k;
    repeat (11) step();
    chk("coalesce_count", log_q.size(), n + 2);
    chk("coalesce_digit", log_q[n+1].wc, 1'b0);
    wait_idle(12);

    // idle: refreshes on counter wraps, every third one a config write
    n = log_q.size();
    wait_log(n + 3, 80);
    for (int i = 0; i < 3; i++) begin
      chk("refresh_phase", (log_q[n+i].k - 1) % REFRESH, 0);
      chk("refresh_type", log_q[n+i].wc, (((log_q[n+i].k - 1) / REFRESH) % DIV) == 0);
    end
    wait_idle(12);

    // wrapper never acks
    wait_phase(1);
    n = log_q.size();
    resp_en = 1'b0;
    t0 = to_count;
    config_stb = 1'b1; step(); config_stb = 1'b0;
    repeat (10) step();
`ifdef DISPLAY_SCHED_TIMEOUT_EN
    chk("timeout_pulses", to_count - t0, 1);
    resp_en = 1'b1;
    wait_log(n + 2, 10);
    chk("after_timeout_config", log_q[n+1].wc, 1'b1);
`else
    repeat (10) step();
    chk("no_ack_busy_held", o_busy, 1'b1);
    chk("no_ack_no_timeout", to_count - t0, 0);
    reset_n = 1'b0; step(); step();
    chk("midreset_busy", o_busy, 1'b0);
    chk("midreset_wc", dif.write_config, 1'b0);
    resp_en = 1'b1;
    ack_cnt = 0;
    n = log_q.size();
    reset_n = 1'b1;
    wait_log(n + 1, 10);
    chk("midreset_first_edge", log_q[n].k, 1);
    chk("midreset_first_config", log_q[n].wc, 1'b1);
`endif
    wait_idle(25);

    // randomized requests, display busy and live time values
    for (int i = 0; i < 500; i++) begin
      time_stb   = ($urandom % 8) == 0;
      config_stb = ($urandom % 16) == 0;
      busy_r     = ($urandom % 4) == 0;
      hours_i    = 5'($urandom);
      minutes_i  = 6'($urandom);
      seconds_i  = 6'($urandom);
      dp_i       = 6'($urandom);
      step();
    end
    time_stb = 1'b0; config_stb = 1'b0; busy_r = 1'b0;
    wait_idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
